// File: rtl/rv32im_issue_ctrl.sv
// Issue sequencer between fetch and decode: scoreboards in-flight rd writes, stalls on
// RAW/WAW hazards and holds issue while a control transfer resolves, flushing decode on taken.
module rv32im_issue_ctrl #(
    parameter int XLEN         = 32,
    parameter int REG_BITS     = 5,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                              clk_i,
    input  logic                              clear_i,
    input  logic                              instr_valid_i,
    input  logic [XLEN-1:0]                   instruction_i,
    output logic                              decode_ready_o,
    output logic                              stall_o,
    input  logic                              wb_valid_i,
    input  logic [REG_BITS-1:0]               wb_rd_i,
    input  logic                              jump_resolved_i,
    input  logic                              jump_taken_i,
    output logic                              decode_flush_o,
    output logic                              clear_branch_stall_o,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o,
    output logic [1:0]                        state_o
);
    localparam int NREG = 1 << REG_BITS;
    localparam int CW   = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_JUMP_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH     = 2'd2;

    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_AUIPC = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b11011;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_A     = 5'b01100;
    localparam logic [4:0] OP_S     = 5'b01000;
    localparam logic [4:0] OP_B     = 5'b11000;
    localparam logic [4:0] OP_FENCE = 5'b00011;
    localparam logic [4:0] OP_SYS   = 5'b11100;

    function automatic logic [NREG-1:0] onehot(input logic [REG_BITS-1:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    logic [1:0]          state;
    logic [NREG-1:0]     pend;
    logic [NREG-1:0]     pend_next;
    logic [NREG-1:0]     wb_mask;
    logic [NREG-1:0]     eff;
    logic [CW-1:0]       inflight_next;
    logic [4:0]          op;
    logic [REG_BITS-1:0] rd;
    logic [REG_BITS-1:0] rs1;
    logic [REG_BITS-1:0] rs2;
    logic                uses_rs1;
    logic                uses_rs2;
    logic                writes_rd;
    logic                is_ctrl;
    logic                wb_frees;
    logic                hazard;
    logic                issue_wr;
    logic                unused_bits;

    assign op  = instruction_i[6:2];
    assign rd  = instruction_i[7 +: REG_BITS];
    assign rs1 = instruction_i[15 +: REG_BITS];
    assign rs2 = instruction_i[20 +: REG_BITS];
    assign unused_bits = ^{instruction_i[XLEN-1:25], instruction_i[1:0]};

    always_comb begin
        uses_rs1  = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
        uses_rs2  = (op == OP_A || op == OP_S || op == OP_B);
        writes_rd = (rd != '0) && !(op == OP_S || op == OP_B || op == OP_FENCE);
        is_ctrl   = (op == OP_JAL || op == OP_JALR || op == OP_B || op == OP_SYS);
    end

    // A same-cycle writeback is removed from the hazard view so the consumer issues at once.
    assign wb_mask  = wb_valid_i ? onehot(wb_rd_i) : '0;
    assign eff      = pend & ~wb_mask;
    assign wb_frees = wb_valid_i & pend[wb_rd_i];

    assign hazard = (uses_rs1 & eff[rs1])
                  | (uses_rs2 & eff[rs2])
                  | (writes_rd & eff[rd])
                  | (writes_rd & (inflight_o == MAX_CNT) & ~wb_frees);

    assign decode_ready_o = (state == ST_RUN) & instr_valid_i & ~hazard;
    assign stall_o        = instr_valid_i & ~decode_ready_o;
    assign issue_wr       = decode_ready_o & writes_rd;
    assign state_o        = state;

    // Clearing before setting lets a re-issue of the retiring register keep its bit.
    always_comb begin
        pend_next    = (pend & ~wb_mask) | (issue_wr ? onehot(rd) : '0);
        pend_next[0] = 1'b0;
        inflight_next = inflight_o;
        case ({issue_wr, wb_frees})
            2'b10:   inflight_next = inflight_o + CW'(1);
            2'b01:   inflight_next = inflight_o - CW'(1);
            default: inflight_next = inflight_o;
        endcase
    end

    always_ff @(posedge clk_i or posedge clear_i) begin
        if (clear_i) begin
            state                <= ST_RUN;
            pend                 <= '0;
            inflight_o           <= '0;
            decode_flush_o       <= 1'b0;
            clear_branch_stall_o <= 1'b0;
        end else begin
            pend                 <= pend_next;
            inflight_o           <= inflight_next;
            decode_flush_o       <= 1'b0;
            clear_branch_stall_o <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (decode_ready_o && is_ctrl) state <= ST_JUMP_WAIT;
                end
                ST_JUMP_WAIT: begin
                    if (jump_resolved_i) begin
                        clear_branch_stall_o <= 1'b1;
                        if (jump_taken_i) begin
                            state          <= ST_FLUSH;
                            decode_flush_o <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_FLUSH: state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end
endmodule
